// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_MAJORITY_EN (set in uart_receiver) selects 2-of-3 voting per bit.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;
    localparam int CNT_W      = $clog2(OVERSAMPLE);
    localparam int IDX_W      = $clog2(DATA_BITS);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// RESET_VAL is the value both flops take while rst_ni is low.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_q    <= r_meta;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampling UART receiver: 8 data bits, optional parity, one stop bit.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote over tick counts 6/7/8.
module uart_receiver
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        baud_tick_x16_i,
    input  logic        rx_i,
    input  logic        rx_en_i,
    input  logic        parity_en_i,
    input  logic        parity_odd_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output uart_state_e dbg_state_o
);

    uart_state_e              r_state;
    uart_state_e              w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [DATA_BITS-1:0]     r_shift;
    logic [DATA_BITS-1:0]     r_data;
    logic                     r_valid;
    logic                     r_parity_err;
    logic                     r_frame_err;
    logic                     r_perr_acc;
    logic                     r_par_en;
    logic                     r_par_odd;
    logic                     w_rx;
    logic                     w_tick;
    logic                     w_resolve;
    logic                     w_bit;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rx_i),
        .q_o    (w_rx)
    );

    // Ticks only count while enabled; a disabled receiver sees no time pass.
    assign w_tick = baud_tick_x16_i & rx_en_i;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] RESOLVE_CNT = CNT_W'(MID_SAMPLE + 1);
    logic r_s6;
    logic r_s7;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s6 <= 1'b1;
            r_s7 <= 1'b1;
        end else if (w_tick) begin
            if (r_cnt == CNT_W'(MID_SAMPLE - 1)) r_s6 <= w_rx;
            if (r_cnt == CNT_W'(MID_SAMPLE))     r_s7 <= w_rx;
        end
    end

    assign w_bit = maj3(r_s6, r_s7, w_rx);
`else
    localparam logic [CNT_W-1:0] RESOLVE_CNT = CNT_W'(MID_SAMPLE);
    assign w_bit = w_rx;
`endif

    assign w_resolve = w_tick && (r_cnt == RESOLVE_CNT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_tick && !w_rx) w_state_nxt = ST_START;
            ST_START:  if (w_resolve) w_state_nxt = w_bit ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_resolve && r_idx == IDX_W'(DATA_BITS - 1))
                           w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_resolve) w_state_nxt = ST_STOP;
            ST_STOP:   if (w_resolve) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (!rx_en_i) w_state_nxt = ST_IDLE;
    end

    // Datapath: counters, shift register and the one-clk result pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_perr_acc   <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            if (!rx_en_i) begin
                r_cnt <= '0;
                r_idx <= '0;
            end else if (w_tick) begin
                if (r_state == ST_IDLE || w_state_nxt == ST_IDLE) r_cnt <= '0;
                else                                              r_cnt <= r_cnt + 1'b1;

                if (r_state == ST_START && w_resolve && !w_bit) begin
                    r_par_en   <= parity_en_i;
                    r_par_odd  <= parity_odd_i;
                    r_idx      <= '0;
                    r_perr_acc <= 1'b0;
                end
                if (r_state == ST_DATA && w_resolve) begin
                    r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                    r_idx   <= r_idx + 1'b1;
                end
                if (r_state == ST_PARITY && w_resolve)
                    r_perr_acc <= ((^r_shift) ^ w_bit) != r_par_odd;
                if (r_state == ST_STOP && w_resolve) begin
                    r_data       <= r_shift;
                    r_valid      <= 1'b1;
                    r_parity_err <= r_perr_acc;
                    r_frame_err  <= !w_bit;
                end
            end
        end
    end

    assign rx_data_o    = r_data;
    assign rx_valid_o   = r_valid;
    assign parity_err_o = r_parity_err;
    assign frame_err_o  = r_frame_err;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized ones,
// compared against a frame-level model of the serial protocol.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int BAUDS_LIM = 3;
    localparam int BIT_CLKS  = 16 * (BAUDS_LIM + 1);

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        baud_tick_x16_i = 1'b0;
    logic        rx_i = 1'b1;
    logic        rx_en_i = 1'b0;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        parity_err_o;
    logic        frame_err_o;
    uart_state_e dbg_state_o;

    int          checks = 0;
    int          failures = 0;
    int          bad_pulse = 0;
    int          bad_err = 0;
    int          div = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  last_data = 8'h00;
    logic [9:0]  exp_q[$];
    logic [9:0]  obs_q[$];

    uart_receiver dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .baud_tick_x16_i (baud_tick_x16_i),
        .rx_i            (rx_i),
        .rx_en_i         (rx_en_i),
        .parity_en_i     (parity_en_i),
        .parity_odd_i    (parity_odd_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .parity_err_o    (parity_err_o),
        .frame_err_o     (frame_err_o),
        .dbg_state_o     (dbg_state_o)
    );

    // Clock and baud tick (one tick every BAUDS_LIM+1 clocks).
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (div == BAUDS_LIM) begin
            div = 0;
            baud_tick_x16_i = 1'b1;
        end else begin
            div = div + 1;
            baud_tick_x16_i = 1'b0;
        end
    end

    // Output monitor: records {frame_err, parity_err, data} per valid pulse.
    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            obs_q.push_back({frame_err_o, parity_err_o, rx_data_o});
            if (prev_valid) bad_pulse = bad_pulse + 1;
        end else if (parity_err_o || frame_err_o) begin
            bad_err = bad_err + 1;
        end
        prev_valid = rx_valid_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        idle_clks(BIT_CLKS);
    endtask

    // Drives one frame and records what the receiver must report for it.
    task automatic send_frame(input logic [7:0] data, input logic pen, input logic podd,
                              input logic pbad, input logic stop_val);
        logic pbit;
        int   ones;
        logic perr;
        ones = $countones(data);
        pbit = ((ones % 2 == 1) != podd) ? 1'b1 : 1'b0;
        if (pbad) pbit = ~pbit;
        parity_en_i  = pen;
        parity_odd_i = podd;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (pen) send_bit(pbit);
        send_bit(stop_val);
        perr = pen && (((ones + int'(pbit)) % 2 == 1) != podd);
        exp_q.push_back({!stop_val, perr, data});
    endtask

    task automatic expect_frames(input string tag);
        int         budget;
        int         n_exp;
        logic [9:0] e;
        logic [9:0] o;
        budget = 0;
        n_exp = exp_q.size();
        while (obs_q.size() < n_exp && budget < 4 * BIT_CLKS) begin
            @(negedge clk_i);
            budget = budget + 1;
        end
        check({tag, "_count"}, obs_q.size(), n_exp);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'bx;
            check(tag, {22'd0, o}, {22'd0, e});
            last_data = e[7:0];
        end
        obs_q.delete();
        check({tag, "_hold"}, rx_data_o, last_data);
    endtask

    initial begin
        logic [7:0] d;
        logic       pen;
        logic       podd;
        logic       pbad;
        logic       stp;

        // Reset values
        rx_en_i = 1'b1;
        idle_clks(5);
        check("rst_data", rx_data_o, 8'h00);
        check("rst_valid", rx_valid_o, 1'b0);
        check("rst_perr", parity_err_o, 1'b0);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_state", dbg_state_o, ST_IDLE);
        rst_ni = 1'b1;
        idle_clks(20);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        expect_frames("a5_plain");

        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        expect_frames("3c_par_ok");
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_clks(BIT_CLKS);
        expect_frames("3c_par_bad");

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b1;
        idle_clks(2 * BIT_CLKS);
        expect_frames("55_stop_low");

        // False start: 4 ticks low, then idle
        rx_i = 1'b0;
        idle_clks(4 * (BAUDS_LIM + 1));
        rx_i = 1'b1;
        idle_clks(2 * BIT_CLKS);
        check("false_start_state", dbg_state_o, ST_IDLE);
        check("false_start_no_valid", obs_q.size(), 0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        expect_frames("0f_after_false");

        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        expect_frames("back_to_back");

        for (int k = 0; k < 12; k++) begin
            d    = 8'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pbad = ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 4) != 0);
            send_frame(d, pen, podd, pbad, stp);
            rx_i = 1'b1;
            idle_clks(stp ? $urandom_range(0, 20) : 2 * BIT_CLKS);
            expect_frames("random");
        end

        // Receiver disabled mid-data: frame abandoned, byte retained
        parity_en_i = 1'b0;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_en_i = 1'b0;
        rx_i = 1'b1;
        idle_clks(2);
        check("dis_state", dbg_state_o, ST_IDLE);
        idle_clks(3 * BIT_CLKS);
        rx_en_i = 1'b1;
        idle_clks(2 * BIT_CLKS);
        check("dis_no_valid", obs_q.size(), 0);
        check("dis_data_kept", rx_data_o, last_data);

        // Reset mid-frame: frame discarded, outputs at reset values
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_ni = 1'b0;
        rx_i = 1'b1;
        idle_clks(2);
        check("midrst_state", dbg_state_o, ST_IDLE);
        check("midrst_data", rx_data_o, 8'h00);
        rst_ni = 1'b1;
        idle_clks(2 * BIT_CLKS);
        check("midrst_no_valid", obs_q.size(), 0);
        last_data = 8'h00;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_clks(BIT_CLKS);
        expect_frames("c3_after_reset");

`ifdef UART_RX_MAJORITY_EN
        // One-tick glitch near the centre of data bit 2 must be voted out
        parity_en_i = 1'b0;
        d = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                rx_i = d[i];
                idle_clks(30);
                rx_i = ~d[i];
                idle_clks(BAUDS_LIM + 1);
                rx_i = d[i];
                idle_clks(BIT_CLKS - 30 - (BAUDS_LIM + 1));
            end else begin
                send_bit(d[i]);
            end
        end
        send_bit(1'b1);
        exp_q.push_back({2'b00, d});
        idle_clks(BIT_CLKS);
        expect_frames("glitch_vote");
`endif

        check("single_clk_pulse", bad_pulse, 0);
        check("err_only_with_valid", bad_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
